inst_fetch_unit: RTL and testbench

- Instruction-fetch stage sitting directly upstream of the instruction decoders (I/R/S/B/U/J-type).
- Holds the PC and issues sequential word requests to instruction memory over a valid/ready handshake.
- Buffers the in-order responses in a small FIFO and presents one 32-bit instruction_word plus its PC to the decode stage with valid/ready.
- Accepts a redirect (branch/jump target) that flushes the buffer and discards stale in-flight responses.

---
 rtl/inst_fetch_unit.sv | 135 +++++++++++++
 tb/tb_inst_fetch_unit.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit
//   Instruction-fetch stage feeding the decoders. Keeps the fetch PC, issues
//   sequential word requests to instruction memory, buffers the in-order
//   responses in a small FIFO and hands {instruction_word, inst_pc} to decode.
//   A redirect restarts fetch at a new target, flushes the buffer and marks
//   every still-outstanding response as stale so it gets discarded on arrival.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   imem_req_valid/ready/addr fetch request handshake, word-aligned address
//   imem_resp_valid/data      in-order responses, one per accepted request
//   instruction_word, inst_pc head of the buffer (zero when empty)
//   inst_valid, inst_ready    decode-side handshake
//   redirect_valid/pc         one-cycle restart pulse and target address
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic [31:0] instruction_word,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW:0]   DEPTH_C  = (CW + 1)'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

    logic [31:0]   pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] inflight;
    logic [CW-1:0] inflight_nxt;
    logic [CW-1:0] drop;
    logic [CW-1:0] count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   buf_data [FIFO_DEPTH];
    logic [31:0]   buf_pc   [FIFO_DEPTH];

    logic [CW:0]   credit_used;
    logic          req_fire;
    logic          resp_take;
    logic          push;
    logic          pop;
    logic [31:0]   redirect_aligned;

    // Outstanding requests and buffered entries share one credit pool, which
    // is what guarantees a response always finds a free FIFO slot.
    assign credit_used      = {1'b0, inflight} + {1'b0, count};
    assign imem_req_valid   = !rst && !redirect_valid && (credit_used < DEPTH_C);
    assign imem_req_addr    = pc;
    assign req_fire         = imem_req_valid && imem_req_ready;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign resp_take        = imem_resp_valid && (inflight != '0);
    // Stale responses (drop > 0) are eaten; a response in a redirect cycle is
    // stale by definition, so it is never pushed either.
    assign push             = resp_take && (drop == '0) && !redirect_valid;
    assign pop              = inst_valid && inst_ready && !redirect_valid;
    assign redirect_aligned = {redirect_pc[31:2], 2'b00};

    assign inst_valid       = (count != '0);
    assign instruction_word = inst_valid ? buf_data[rd_ptr] : 32'h0;
    assign inst_pc          = inst_valid ? buf_pc[rd_ptr]   : 32'h0;

    always_comb begin
        inflight_nxt = inflight;
        if (req_fire && !resp_take) begin
            inflight_nxt = inflight + CW'(1);
        end else if (!req_fire && resp_take) begin
            inflight_nxt = inflight - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            resp_pc  <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            inflight <= inflight_nxt;
            if (redirect_valid) begin
                pc      <= redirect_aligned;
                resp_pc <= redirect_aligned;
                // Everything still outstanding after this cycle belongs to
                // the old stream.
                drop    <= inflight_nxt;
                count   <= '0;
                rd_ptr  <= '0;
                wr_ptr  <= '0;
            end else begin
                if (req_fire) begin
                    pc <= pc + 32'd4;
                end
                if (resp_take && (drop != '0)) begin
                    drop <= drop - CW'(1);
                end
                if (push) begin
                    resp_pc <= resp_pc + 32'd4;
                    wr_ptr  <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
                end
                if (push && !pop) begin
                    count <= count + CW'(1);
                end else if (!push && pop) begin
                    count <= count - CW'(1);
                end
            end
        end
    end

    // Storage needs no reset: the outputs are masked while count is zero.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_data[wr_ptr] <= imem_resp_data;
            buf_pc[wr_ptr]   <= resp_pc;
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'h0;
    logic [31:0] instruction_word;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    inst_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .instruction_word(instruction_word), .inst_pc(inst_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] data;
    } mem_ent_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_ent_t;

    typedef struct {
        int   cycles;
        logic dec_rdy;
        logic mem_rdy;
        int   lat;
        int   exp_req_valid;   // -1: don't care
        int   exp_inst_valid;  // -1: don't care
        int   min_deliv;       // 0: no throughput check
    } phase_t;

    mem_ent_t    mem_q[$];
    exp_ent_t    exp_q[$];
    logic [31:0] exp_pc = RESET_PC;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          delivered = 0;
    int          first_valid_cyc = -1;
    bit          have_pop = 0;
    logic [31:0] first_pop_pc = 32'h0;

    logic        dec_rdy = 1'b1;
    logic        mem_rdy = 1'b1;
    int          lat = 1;
    bit          redir = 0;
    logic [31:0] redir_pc = 32'h0;
    bit          spurious = 0;
    bit          coinc_arm = 0;
    bit          coinc_hit = 0;

    function automatic logic [31:0] memfn(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs on the falling edge, sample 1 time unit
    // later, then advance the memory and scoreboard models for the next edge.
    task automatic step();
        bit       do_redir;
        bit       resp_from_q;
        exp_ent_t e;
        mem_ent_t m;
        @(negedge clk);
        do_redir    = redir;
        resp_from_q = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        if (coinc_arm && resp_from_q && inst_valid && dec_rdy) begin
            do_redir  = 1;
            coinc_arm = 0;
            coinc_hit = 1;
        end
        inst_ready     = dec_rdy;
        imem_req_ready = mem_rdy;
        redirect_valid = do_redir;
        redirect_pc    = redir_pc;
        if (resp_from_q) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_q[0].data;
        end else if (spurious && mem_q.size() == 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = 32'hDEAD_BEEF;
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end
        #1;
        if (do_redir) chk("redir_no_req", 32'(imem_req_valid), 32'd0);
        if (imem_req_valid) chk("req_addr", imem_req_addr, exp_pc);
        if (inst_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stale_out: actual pc=%h word=%h required no valid output (cycle %0d)",
                         inst_pc, instruction_word, cyc);
            end else begin
                chk("inst_pc", inst_pc, exp_q[0].pc);
                chk("inst_word", instruction_word, exp_q[0].data);
            end
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
        end else begin
            chk("empty_word", instruction_word, 32'h0);
            chk("empty_pc", inst_pc, 32'h0);
        end
        if (resp_from_q) void'(mem_q.pop_front());
        if (inst_valid && inst_ready && exp_q.size() > 0) begin
            if (!have_pop) begin
                have_pop     = 1;
                first_pop_pc = exp_q[0].pc;
            end
            void'(exp_q.pop_front());
            delivered++;
        end
        if (imem_req_valid && imem_req_ready) begin
            e.pc   = exp_pc;
            e.data = memfn(exp_pc);
            exp_q.push_back(e);
            m.due  = cyc + lat;
            m.data = e.data;
            mem_q.push_back(m);
            exp_pc = exp_pc + 32'd4;
        end
        if (do_redir) begin
            exp_q.delete();
            exp_pc   = {redir_pc[31:2], 2'b00};
            have_pop = 0;
        end
        cyc++;
    endtask

    task automatic wait_first_pop(string name, logic [31:0] exp);
        for (int i = 0; i < 30 && !have_pop; i++) step();
        chk(name, have_pop ? first_pop_pc : 32'hFFFF_FFFF, exp);
    endtask

    phase_t tbl[5];

    initial begin
        tbl[0] = '{cycles: 12, dec_rdy: 1'b1, mem_rdy: 1'b1, lat: 1, exp_req_valid: -1, exp_inst_valid: -1, min_deliv: 5};
        tbl[1] = '{cycles: 10, dec_rdy: 1'b0, mem_rdy: 1'b1, lat: 1, exp_req_valid:  0, exp_inst_valid:  1, min_deliv: 0};
        tbl[2] = '{cycles: 12, dec_rdy: 1'b1, mem_rdy: 1'b1, lat: 2, exp_req_valid: -1, exp_inst_valid: -1, min_deliv: 3};
        tbl[3] = '{cycles:  6, dec_rdy: 1'b1, mem_rdy: 1'b0, lat: 2, exp_req_valid:  1, exp_inst_valid:  0, min_deliv: 0};
        tbl[4] = '{cycles: 14, dec_rdy: 1'b1, mem_rdy: 1'b1, lat: 3, exp_req_valid: -1, exp_inst_valid: -1, min_deliv: 3};

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_word", instruction_word, 32'h0);
        chk("rst_pc", inst_pc, 32'h0);
        chk("rst_addr", imem_req_addr, RESET_PC);
        rst = 1'b0;
        cyc = 0;

        // Start-up latency with a 1-cycle memory
        dec_rdy = 1'b1; mem_rdy = 1'b1; lat = 1;
        repeat (4) step();
        chk("first_valid_cycle", 32'(first_valid_cyc), 32'd2);
        chk("first_pop_pc", have_pop ? first_pop_pc : 32'hFFFF_FFFF, RESET_PC);

        for (int p = 0; p < 5; p++) begin
            int d0;
            dec_rdy = tbl[p].dec_rdy;
            mem_rdy = tbl[p].mem_rdy;
            lat     = tbl[p].lat;
            d0      = delivered;
            repeat (tbl[p].cycles) step();
            if (tbl[p].exp_req_valid >= 0)
                chk($sformatf("phase%0d_req_valid", p), 32'(imem_req_valid), 32'(tbl[p].exp_req_valid));
            if (tbl[p].exp_inst_valid >= 0)
                chk($sformatf("phase%0d_inst_valid", p), 32'(inst_valid), 32'(tbl[p].exp_inst_valid));
            if (tbl[p].min_deliv > 0)
                chk($sformatf("phase%0d_throughput", p), 32'((delivered - d0) >= tbl[p].min_deliv), 32'd1);
        end

        // Response with nothing outstanding must be ignored
        dec_rdy = 1'b1; mem_rdy = 1'b0;
        for (int i = 0; i < 10 && (mem_q.size() != 0 || inst_valid); i++) step();
        spurious = 1;
        step();
        spurious = 0;
        step();
        chk("spurious_ignored", 32'(inst_valid), 32'd0);
        mem_rdy = 1'b1;
        lat = 1;
        repeat (6) step();

        // Redirect with two requests outstanding
        lat = 3;
        for (int i = 0; i < 20 && mem_q.size() != 2; i++) step();
        redir = 1; redir_pc = 32'h0000_0103;
        step();
        redir = 0;
        step();
        chk("flush_empty", 32'(inst_valid), 32'd0);
        chk("redir_addr", imem_req_addr, 32'h0000_0100);
        wait_first_pop("redir_first_pc", 32'h0000_0100);

        // Redirect landing on the same cycle as a response and a pop
        lat = 1;
        redir_pc  = 32'h0000_0200;
        coinc_hit = 0;
        coinc_arm = 1;
        for (int i = 0; i < 20 && !coinc_hit; i++) step();
        coinc_arm = 0;
        chk("coinc_seen", 32'(coinc_hit), 32'd1);
        wait_first_pop("coinc_first_pc", 32'h0000_0200);

        // Back-to-back redirects: the later one wins
        lat = 2;
        repeat (3) step();
        redir = 1; redir_pc = 32'h0000_0300;
        step();
        redir_pc = 32'h0000_0402;
        step();
        redir = 0;
        wait_first_pop("b2b_first_pc", 32'h0000_0400);

        // Asynchronous reset with the buffer full
        dec_rdy = 1'b0; lat = 1;
        repeat (8) step();
        chk("pre_rst_full", 32'(inst_valid), 32'd1);
        @(negedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("async_rst_word", instruction_word, 32'h0);
        chk("async_rst_pc", inst_pc, 32'h0);
        chk("async_rst_req_valid", 32'(imem_req_valid), 32'd0);
        mem_q.delete();
        exp_q.delete();
        exp_pc = RESET_PC;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        cyc = 0;
        first_valid_cyc = -1;
        have_pop = 0;
        dec_rdy = 1'b1;
        repeat (8) step();
        chk("rst2_first_valid_cycle", 32'(first_valid_cyc), 32'd2);
        chk("rst2_first_pop_pc", have_pop ? first_pop_pc : 32'hFFFF_FFFF, RESET_PC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
